issue_scheduler: RTL and testbench

- Single-issue scheduler for the out-of-order RISC-V backend.
- Arbitrates the four execution queues (integer, multiply, divide, load/store) and produces the per-unit issue_granted pulses.
- Tracks future CDB occupancy so that no two units ever drive the CDB in the same cycle.
- Provides the registered CDB source select used by the CDB mux.

---
 rtl/issue_scheduler_pkg.sv | 18 +
 rtl/ffd_param.sv | 16 +
 rtl/issue_scheduler_rr_arbiter4.sv | 39 +++
 rtl/issue_scheduler.sv | 104 ++++++++++
 tb/tb_issue_scheduler.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared types and default latencies for the single-issue scheduler.
package issue_scheduler_pkg;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MULT = 2'd1,
        UNIT_DIV  = 2'd2,
        UNIT_LS   = 2'd3
    } issue_unit_e;

    localparam int NUM_UNITS    = 4;
    localparam int INT_LAT_DEF  = 1;
    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 6;
    localparam int LS_LAT_DEF   = 2;
    localparam int MAX_LAT_DEF  = 6;

endpackage

// File: rtl/ffd_param.sv
// Width-parameterised D flop bank with asynchronous active-low clear.
module ffd_param #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/issue_scheduler_rr_arbiter4.sv
// Four-way round-robin arbiter: the search starts at ptr, which moves past the winner.
module rr_arbiter4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] eligible,
    output logic [3:0] grant
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int u = 0; u < 4; u++) begin
            if (grant[u]) ptr_d = 2'(u) + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue scheduler: picks one ready unit per cycle whose CDB slot is free and
// keeps a shifting reservation vector whose slot 0 is the registered CDB select.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int INT_LAT  = INT_LAT_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int LS_LAT   = LS_LAT_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_ready,
    input  logic       mult_ready,
    input  logic       div_ready,
    input  logic       ls_ready,
    output logic       int_issue_granted,
    output logic       mult_issue_granted,
    output logic       div_issue_granted,
    output logic       ls_issue_granted,
    output logic       cdb_sel_valid,
    output logic [1:0] cdb_sel,
    output logic       div_busy
);

    localparam int DCW = $clog2(MAX_LAT + 1);
    localparam int UNIT_LAT [NUM_UNITS] = '{INT_LAT, MULT_LAT, DIV_LAT, LS_LAT};

    if (INT_LAT < 1 || INT_LAT > MAX_LAT)   begin : g_bad_int_lat  $error("INT_LAT out of range");  end
    if (MULT_LAT < 1 || MULT_LAT > MAX_LAT) begin : g_bad_mult_lat $error("MULT_LAT out of range"); end
    if (DIV_LAT < 1 || DIV_LAT > MAX_LAT)   begin : g_bad_div_lat  $error("DIV_LAT out of range");  end
    if (LS_LAT < 1 || LS_LAT > MAX_LAT)     begin : g_bad_ls_lat   $error("LS_LAT out of range");   end

    logic [MAX_LAT:0]     res_q, res_d;
    logic [2*MAX_LAT+1:0] slot_q, slot_d;
    logic [DCW-1:0]       div_cnt_q, div_cnt_d;
    logic [3:0]           ready, eligible, grant;

    assign ready = {ls_ready, div_ready, mult_ready, int_ready};

    // Gated by rst_n so the grant pulses drop the moment reset is asserted.
    always_comb begin
        eligible = '0;
        if (rst_n) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                eligible[u] = ready[u] & ~res_q[UNIT_LAT[u]];
            end
        end
        if (div_cnt_q != '0) eligible[UNIT_DIV] = 1'b0;
    end

    rr_arbiter4 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .grant    (grant)
    );

    always_comb begin
        res_d  = {1'b0, res_q[MAX_LAT:1]};
        slot_d = {2'b00, slot_q[2*MAX_LAT+1:2]};
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (grant[u]) begin
                res_d[UNIT_LAT[u]-1]           = 1'b1;
                slot_d[2*(UNIT_LAT[u]-1) +: 2] = 2'(u);
            end
        end
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (grant[UNIT_DIV])        div_cnt_d = DCW'(DIV_LAT - 1);
        else if (div_cnt_q != '0)   div_cnt_d = div_cnt_q - 1'b1;
    end

    ffd_param #(.W(MAX_LAT + 1)) u_res_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (res_d),
        .q     (res_q)
    );

    ffd_param #(.W(2 * MAX_LAT + 2)) u_slot_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (slot_d),
        .q     (slot_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end

    assign int_issue_granted  = grant[UNIT_INT];
    assign mult_issue_granted = grant[UNIT_MULT];
    assign div_issue_granted  = grant[UNIT_DIV];
    assign ls_issue_granted   = grant[UNIT_LS];
    assign cdb_sel_valid      = res_q[0];
    assign cdb_sel            = slot_q[1:0];
    assign div_busy           = (div_cnt_q != '0);

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: an absolute-time CDB booking queue and round-robin model
// predict grants, CDB select and divider busy every cycle.
module tb_issue_scheduler;

    localparam int LAT [4] = '{1, 4, 6, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       int_ready = 1'b0, mult_ready = 1'b0, div_ready = 1'b0, ls_ready = 1'b0;
    logic       int_issue_granted, mult_issue_granted, div_issue_granted, ls_issue_granted;
    logic       cdb_sel_valid;
    logic [1:0] cdb_sel;
    logic       div_busy;

    int checks = 0;
    int errors = 0;

    // Model state: exp_q[k] = expected {valid, unit} on the CDB k cycles from now.
    logic [2:0] exp_q[$];
    int         cyc;
    int         ptr;
    int         last_div;

    issue_scheduler dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .int_ready          (int_ready),
        .mult_ready         (mult_ready),
        .div_ready          (div_ready),
        .ls_ready           (ls_ready),
        .int_issue_granted  (int_issue_granted),
        .mult_issue_granted (mult_issue_granted),
        .div_issue_granted  (div_issue_granted),
        .ls_issue_granted   (ls_issue_granted),
        .cdb_sel_valid      (cdb_sel_valid),
        .cdb_sel            (cdb_sel),
        .div_busy           (div_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] observed_grants();
        return {ls_issue_granted, div_issue_granted, mult_issue_granted, int_issue_granted};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cyc      = 0;
        ptr      = 0;
        last_div = -100;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({observed_grants(), cdb_sel_valid, cdb_sel, div_busy} !== 8'b0) begin
            errors++;
            $display("FAIL %s outputs got g=%b v=%b sel=%0d busy=%b required all 0",
                     name, observed_grants(), cdb_sel_valid, cdb_sel, div_busy);
        end
    endtask

    // Drive one cycle of readies, check every output against the model, advance.
    task automatic step(input logic [3:0] rdy, output logic [3:0] g);
        logic [3:0] exp_g;
        logic [2:0] exp_cdb;
        logic       exp_busy;
        int         u;
        {ls_ready, div_ready, mult_ready, int_ready} = rdy;
        @(negedge clk);
        exp_g = '0;
        for (int i = 0; i < 4; i++) begin
            u = (ptr + i) % 4;
            if (exp_g == 0 && rdy[u] &&
                !(exp_q.size() > LAT[u] && exp_q[LAT[u]][2]) &&
                !(u == 2 && cyc < last_div + LAT[2])) begin
                exp_g[u] = 1'b1;
            end
        end
        exp_cdb  = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
        exp_busy = (cyc > last_div) && (cyc < last_div + LAT[2]);
        g = observed_grants();
        checks++;
        if (g !== exp_g) begin
            errors++;
            $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, g, exp_g);
        end
        checks++;
        if (cdb_sel_valid !== exp_cdb[2] || (exp_cdb[2] && cdb_sel !== exp_cdb[1:0])) begin
            errors++;
            $display("FAIL cdb cyc=%0d got v=%b sel=%0d exp v=%b sel=%0d",
                     cyc, cdb_sel_valid, cdb_sel, exp_cdb[2], exp_cdb[1:0]);
        end
        checks++;
        if (div_busy !== exp_busy) begin
            errors++;
            $display("FAIL div_busy cyc=%0d got=%b exp=%b", cyc, div_busy, exp_busy);
        end
        for (int k = 0; k < 4; k++) begin
            if (exp_g[k]) begin
                while (exp_q.size() <= LAT[k]) exp_q.push_back(3'b000);
                exp_q[LAT[k]] = {1'b1, 2'(k)};
                ptr = (k + 1) % 4;
                if (k == 2) last_div = cyc;
            end
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        {ls_ready, div_ready, mult_ready, int_ready} = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        {ls_ready, div_ready, mult_ready, int_ready} = 4'b0000;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [3:0] g;
        apply_reset();
        step(4'b0000, g);
    endtask

    task automatic test_int_only();
        logic [3:0] g;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            step(4'b0001, g);
            checks++;
            if (g !== 4'b0001) begin
                errors++;
                $display("FAIL int_only_grant c=%0d got=%b exp=0001", c, g);
            end
        end
    endtask

    task automatic test_mult_int();
        logic [3:0] g;
        apply_reset();
        step(4'b0010, g);
        for (int c = 1; c < 7; c++) begin
            step(4'b0001, g);
            checks++;
            if (g[0] !== (c != 3)) begin
                errors++;
                $display("FAIL mult_int_grant c=%0d got=%b exp=%b", c, g[0], (c != 3));
            end
        end
    endtask

    task automatic test_div_only();
        logic [3:0] g;
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            step(4'b0100, g);
            checks++;
            if (g[2] !== (c % 6 == 0)) begin
                errors++;
                $display("FAIL div_spacing c=%0d got=%b exp=%b", c, g[2], (c % 6 == 0));
            end
        end
    endtask

    task automatic test_mult_ls();
        logic [3:0] g;
        apply_reset();
        step(4'b0010, g);
        step(4'b0000, g);
        step(4'b1000, g);
        checks++;
        if (g[3] !== 1'b0) begin
            errors++;
            $display("FAIL ls_blocked got=%b exp=0", g[3]);
        end
        step(4'b1000, g);
        checks++;
        if (g[3] !== 1'b1) begin
            errors++;
            $display("FAIL ls_after_block got=%b exp=1", g[3]);
        end
        for (int c = 0; c < 4; c++) step(4'b0000, g);
    endtask

    task automatic test_back_to_back();
        logic [3:0] g;
        int         last [4];
        apply_reset();
        for (int u = 0; u < 4; u++) last[u] = -1;
        for (int c = 0; c < 200; c++) begin
            step(4'b1111, g);
            checks++;
            if ($countones(g) != 1) begin
                errors++;
                $display("FAIL one_grant c=%0d got=%b exp=onehot", c, g);
            end
            for (int u = 0; u < 4; u++) begin
                if (g[u]) last[u] = c;
                if (u != 2 && c - last[u] > 8) begin
                    checks++;
                    errors++;
                    $display("FAIL fairness unit=%0d c=%0d last=%0d exp gap<=8", u, c, last[u]);
                    last[u] = c;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] g;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            step(4'($urandom_range(0, 15)), g);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] g;
        apply_reset();
        step(4'b0100, g);
        step(4'b0000, g);
        step(4'b0000, g);
        {ls_ready, div_ready, mult_ready, int_ready} = 4'b0101;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(4'b0100, g);
        checks++;
        if (g !== 4'b0100) begin
            errors++;
            $display("FAIL div_after_reset got=%b exp=0100", g);
        end
        step(4'b0000, g);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_int_only();
        test_mult_int();
        test_div_only();
        test_mult_ls();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
